// File: rtl/moving_average_filter_if.sv
// Sample-stream interface for moving_average_filter.
// The master drives enable, mode and signal_in; the slave (the filter) returns
// the registered average, its valid strobe and the window-full flag.
interface moving_average_filter_if #(
  parameter int unsigned W = 28
);
  logic                enable;
  logic                mode;
  logic signed [W-1:0] signal_in;
  logic signed [W-1:0] signal_out;
  logic                out_valid;
  logic                window_full;

  modport master (
    output enable,
    output mode,
    output signal_in,
    input  signal_out,
    input  out_valid,
    input  window_full
  );

  modport slave (
    input  enable,
    input  mode,
    input  signal_in,
    output signal_out,
    output out_valid,
    output window_full
  );
endinterface

// File: rtl/moving_average_filter.sv
// Decimating moving-average filter for signed sample streams.
// mode=0: block average, one output per N = 2**LOG2N ticks.
// mode=1: sliding window over the last N ticks, one output per tick.
// A tick occurs every DECIM enabled cycles; signal_in is taken in the tick cycle.
// Build option: define MAVG_ROUND_EN to round half toward +inf instead of flooring.
module moving_average_filter #(
  parameter int unsigned W     = 28,
  parameter int unsigned LOG2N = 10,
  parameter int unsigned DECIM = 4
) (
  input logic               clock_in,
  input logic               reset,
  moving_average_filter_if.slave bus
);

  localparam int unsigned N  = 2 ** LOG2N;
  localparam int unsigned AW = W + LOG2N;
  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [DW-1:0]    DecLast  = DW'(DECIM - 1);
  localparam logic [LOG2N-1:0] CntLast  = LOG2N'(N - 1);
  localparam logic [LOG2N:0]   FillFull = (LOG2N + 1)'(N);
  localparam logic [LOG2N:0]   FillLast = (LOG2N + 1)'(N - 1);

  // Registered state
  logic [DW-1:0]       dec_cnt_q, dec_cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [LOG2N-1:0]    cnt_q, cnt_d;
  logic [LOG2N-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LOG2N:0]      fill_q, fill_d;
  logic                mode_q;
  logic signed [W-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;

  // Sliding-window history; never cleared, stale entries masked by fill_q
  logic signed [W-1:0] sample_mem [N];
  logic                mem_we;

  // Datapath
  logic                tick;
  logic                mode_change;
  logic                window_full_now;
  logic signed [AW:0]  x_ext;
  logic signed [AW:0]  old_ext;
  logic signed [AW:0]  acc_ext;
  logic signed [AW:0]  acc_next;
  logic signed [W-1:0] avg;

  assign mode_change     = (bus.mode != mode_q);
  assign tick            = bus.enable && (dec_cnt_q == DecLast);
  assign window_full_now = (fill_q == FillFull);

`ifdef MAVG_ROUND_EN
  localparam logic signed [AW:0] Half = (AW + 1)'(2 ** (LOG2N - 1));
`endif

  // Sum including the current sample; one spare bit keeps add-then-subtract exact
  always_comb begin
    x_ext   = {{(AW + 1 - W){bus.signal_in[W-1]}}, bus.signal_in};
    acc_ext = {acc_q[AW-1], acc_q};
    old_ext = '0;
    if (window_full_now) begin
      old_ext = {{(AW + 1 - W){sample_mem[wr_ptr_q][W-1]}}, sample_mem[wr_ptr_q]};
    end
    if (bus.mode) begin
      acc_next = acc_ext + x_ext - old_ext;
    end else begin
      acc_next = acc_ext + x_ext;
    end
  end

  // Average of the updated window: floor, or round-half-up in the wide temporary
  always_comb begin
`ifdef MAVG_ROUND_EN
    avg = W'((acc_next + Half) >>> LOG2N);
`else
    avg = W'(acc_next >>> LOG2N);
`endif
  end

  // Next-state: mode change clears and discards the tick; otherwise tick or decimate
  always_comb begin
    dec_cnt_d   = dec_cnt_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    mem_we      = 1'b0;

    if (mode_change) begin
      dec_cnt_d = '0;
      acc_d     = '0;
      cnt_d     = '0;
      wr_ptr_d  = '0;
      fill_d    = '0;
    end else if (tick) begin
      dec_cnt_d = '0;
      if (!bus.mode) begin
        if (cnt_q == CntLast) begin
          out_d       = avg;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = AW'(acc_next);
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        mem_we   = 1'b1;
        acc_d    = AW'(acc_next);
        wr_ptr_d = wr_ptr_q + 1'b1;
        out_d    = avg;
        if (!window_full_now) begin
          fill_d = fill_q + 1'b1;
        end
        // Valid once the window holds N samples after this update
        out_valid_d = window_full_now || (fill_q == FillLast);
      end
    end else if (bus.enable) begin
      dec_cnt_d = dec_cnt_q + 1'b1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clock_in) begin
    if (reset) begin
      dec_cnt_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      mode_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dec_cnt_q   <= dec_cnt_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      mode_q      <= bus.mode;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // History write; no reset so it can map onto a RAM
  always_ff @(posedge clock_in) begin
    if (mem_we) begin
      sample_mem[wr_ptr_q] <= bus.signal_in;
    end
  end

  assign bus.signal_out  = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.window_full = window_full_now;

endmodule

// File: tb/tb_moving_average_filter.sv
// Self-checking bench for moving_average_filter (W=28, N=4).
// dut1 uses DECIM=1; dut2 uses DECIM=4 for the decimation scenario.
module tb_moving_average_filter;

  localparam int unsigned W     = 28;
  localparam int unsigned LOG2N = 2;
  localparam int unsigned N     = 4;

  logic clock_in = 1'b0;
  logic reset    = 1'b1;

  always #5 clock_in = ~clock_in;

  moving_average_filter_if #(.W(W)) bus1 ();
  moving_average_filter_if #(.W(W)) bus2 ();

  moving_average_filter #(.W(W), .LOG2N(LOG2N), .DECIM(1)) u_dut1 (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus1)
  );

  moving_average_filter #(.W(W), .LOG2N(LOG2N), .DECIM(4)) u_dut2 (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus2)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected averages, pushed when the completing tick is driven
  logic signed [W-1:0] exp_q [$];
  // Expected signal_out (held value) for each DUT
  logic signed [W-1:0] exp_out1 = '0;
  logic signed [W-1:0] exp_out2 = '0;
  // Reference state
  longint hist [$];
  longint blk_sum = 0;
  int     blk_cnt = 0;

  function automatic logic signed [W-1:0] ref_avg(input longint sum);
`ifdef MAVG_ROUND_EN
    return W'((sum + longint'(1 << (LOG2N - 1))) >>> LOG2N);
`else
    return W'(sum >>> LOG2N);
`endif
  endfunction

  task automatic model_clear();
    blk_sum = 0;
    blk_cnt = 0;
    hist.delete();
  endtask

  task automatic model_block(input logic signed [W-1:0] x, output logic ev);
    ev = 1'b0;
    blk_sum += longint'(x);
    blk_cnt++;
    if (blk_cnt == N) begin
      exp_out1 = ref_avg(blk_sum);
      exp_q.push_back(exp_out1);
      ev = 1'b1;
      blk_sum = 0;
      blk_cnt = 0;
    end
  endtask

  task automatic model_slide(input logic signed [W-1:0] x, output logic ev);
    longint s;
    hist.push_back(longint'(x));
    if (hist.size() > N) void'(hist.pop_front());
    s = 0;
    foreach (hist[i]) s += hist[i];
    exp_out1 = ref_avg(s);
    ev = (hist.size() == N);
    if (ev) exp_q.push_back(exp_out1);
  endtask

  task automatic drive1(input logic en, input logic md, input logic signed [W-1:0] x);
    bus1.enable    = en;
    bus1.mode      = md;
    bus1.signal_in = x;
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  task automatic drive2(input logic en, input logic md, input logic signed [W-1:0] x);
    bus2.enable    = en;
    bus2.mode      = md;
    bus2.signal_in = x;
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      bus1.enable = 1'($urandom); bus1.mode = 1'($urandom); bus1.signal_in = W'($urandom);
      bus2.enable = 1'($urandom); bus2.mode = 1'($urandom); bus2.signal_in = W'($urandom);
      @(posedge clock_in);
      @(negedge clock_in);
      total++;
      if (bus1.signal_out !== '0) begin
        bad++; $display("FAIL reset_out: got %0d want 0", bus1.signal_out);
      end
      total++;
      if (bus1.out_valid !== 1'b0) begin
        bad++; $display("FAIL reset_valid: got %b want 0", bus1.out_valid);
      end
      total++;
      if (bus1.window_full !== 1'b0) begin
        bad++; $display("FAIL reset_wfull: got %b want 0", bus1.window_full);
      end
      total++;
      if (bus2.signal_out !== '0 || bus2.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_dut2: got out=%0d valid=%b want 0/0", bus2.signal_out, bus2.out_valid);
      end
    end
    bus2.enable = 1'b0; bus2.mode = 1'b0; bus2.signal_in = '0;
    reset = 1'b0;
    drive1(1'b0, 1'b0, '0);
    model_clear();
    exp_out1 = '0;
  endtask

  // Shared body for DECIM=1 streams: drive one tick and check dut1 against the model
  task automatic test_stream(input string name, input logic md, input int vals []);
    logic signed [W-1:0] x, e;
    logic ev;
    foreach (vals[i]) begin
      x = W'(vals[i]);
      if (md) model_slide(x, ev);
      else    model_block(x, ev);
      drive1(1'b1, md, x);
      total++;
      if (bus1.out_valid !== ev) begin
        bad++; $display("FAIL %s_valid[%0d]: got %b want %b", name, i, bus1.out_valid, ev);
      end
      if (ev) begin
        e = exp_q.pop_front();
        total++;
        if (bus1.signal_out !== e) begin
          bad++; $display("FAIL %s_avg[%0d]: got %0d want %0d", name, i, bus1.signal_out, e);
        end
      end
      total++;
      if (bus1.signal_out !== exp_out1) begin
        bad++; $display("FAIL %s_out[%0d]: got %0d want %0d", name, i, bus1.signal_out, exp_out1);
      end
      total++;
      if (bus1.window_full !== (hist.size() == N)) begin
        bad++;
        $display("FAIL %s_wfull[%0d]: got %b want %b", name, i, bus1.window_full, hist.size() == N);
      end
    end
  endtask

  // A cycle with a mode change (or idle): no pulse, output held, window not full
  task automatic test_clear_cycle(input string name, input logic en, input logic md);
    model_clear();
    drive1(en, md, W'(999));
    total++;
    if (bus1.out_valid !== 1'b0 || bus1.signal_out !== exp_out1 || bus1.window_full !== 1'b0) begin
      bad++;
      $display("FAIL %s: got valid=%b out=%0d wfull=%b want 0/%0d/0", name, bus1.out_valid,
               bus1.signal_out, bus1.window_full, exp_out1);
    end
  endtask

  task automatic test_block();
    test_stream("block", 1'b0, '{10, 20, 30, 40, -1, -1, -1, -1,
                                 134217727, 134217727, 134217727, 134217727});
    total++;
    if (bus1.signal_out !== 28'sd134217727) begin
      bad++; $display("FAIL block_max: got %0d want 134217727", bus1.signal_out);
    end
  endtask

  task automatic test_sliding();
    int v [];
    test_clear_cycle("slide_enter", 1'b0, 1'b1);
    v = new[20];
    foreach (v[i]) begin
      if (i < 4)      v[i] = 100;
      else if (i < 8) v[i] = 200;
      else            v[i] = int'(W'($urandom)) <<< 4 >>> 4;
    end
    test_stream("slide", 1'b1, v);
  endtask

  task automatic test_rounding();
    test_clear_cycle("round_enter", 1'b0, 1'b0);
    test_stream("round_pos", 1'b0, '{1, 1, 1, 0});
    total++;
`ifdef MAVG_ROUND_EN
    if (bus1.signal_out !== 28'sd1) begin
      bad++; $display("FAIL round_pos_val: got %0d want 1", bus1.signal_out);
    end
`else
    if (bus1.signal_out !== 28'sd0) begin
      bad++; $display("FAIL round_pos_val: got %0d want 0", bus1.signal_out);
    end
`endif
    test_stream("round_neg", 1'b0, '{-1, -1, -1, 0});
    total++;
    if (bus1.signal_out !== -28'sd1) begin
      bad++; $display("FAIL round_neg_val: got %0d want -1", bus1.signal_out);
    end
  endtask

  task automatic test_mode_flip();
    test_clear_cycle("flip_enter", 1'b0, 1'b1);
    test_stream("flip_pre", 1'b1, '{50, 60});
    test_clear_cycle("flip_away", 1'b1, 1'b0);
    test_clear_cycle("flip_back", 1'b1, 1'b1);
    test_stream("flip_refill", 1'b1, '{7, 8, 9, 10});
    test_stream("flip_part", 1'b1, '{300, 400});
    reset = 1'b1;
    drive1(1'b1, 1'b1, W'(5));
    total++;
    if (bus1.signal_out !== '0 || bus1.out_valid !== 1'b0 || bus1.window_full !== 1'b0) begin
      bad++;
      $display("FAIL flip_reset: got out=%0d valid=%b wfull=%b want 0/0/0", bus1.signal_out,
               bus1.out_valid, bus1.window_full);
    end
    reset = 1'b0;
    exp_out1 = '0;
    // mode_q restarts at 0, so holding mode=1 is itself a clearing change
    test_clear_cycle("flip_post_reset", 1'b1, 1'b1);
    test_stream("flip_fresh", 1'b1, '{11, 12, 13, 14});
  endtask

  task automatic test_decim();
    int dcnt = 0;
    int ticks = 0;
    longint s = 0;
    int c = 0;
    logic en, ev;
    logic signed [W-1:0] x, e;
    exp_out2 = '0;
    for (int i = 0; i < 160; i++) begin
      en = (i >= 60 && i < 68) ? 1'b0 : 1'($urandom_range(0, 1));
      x  = W'($urandom);
      ev = 1'b0;
      if (en) begin
        if (dcnt == 3) begin
          dcnt = 0;
          ticks++;
          s += longint'(x);
          c++;
          if (c == N) begin
            exp_out2 = ref_avg(s);
            exp_q.push_back(exp_out2);
            ev = 1'b1;
            s = 0;
            c = 0;
          end
        end else begin
          dcnt++;
        end
      end
      drive2(en, 1'b0, x);
      total++;
      if (bus2.out_valid !== ev) begin
        bad++; $display("FAIL decim_valid[%0d]: got %b want %b", i, bus2.out_valid, ev);
      end
      if (ev) begin
        e = exp_q.pop_front();
        total++;
        if (bus2.signal_out !== e) begin
          bad++; $display("FAIL decim_avg[%0d]: got %0d want %0d", i, bus2.signal_out, e);
        end
      end
      total++;
      if (bus2.signal_out !== exp_out2 || bus2.window_full !== 1'b0) begin
        bad++;
        $display("FAIL decim_out[%0d]: got %0d/%b want %0d/0", i, bus2.signal_out,
                 bus2.window_full, exp_out2);
      end
    end
    bus2.enable = 1'b0;
  endtask

  initial begin
    bus1.enable = 1'b0; bus1.mode = 1'b0; bus1.signal_in = '0;
    bus2.enable = 1'b0; bus2.mode = 1'b0; bus2.signal_in = '0;
    test_reset();
    test_block();
    test_sliding();
    test_rounding();
    test_mode_flip();
    test_decim();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
